// File: rtl/mult_seq_ctrl_if.sv
// Control bundle between host, mult_seq_ctrl and the multiplier datapath.
// slave = the controller, master = host plus datapath side.
interface mult_seq_ctrl_if #(
   parameter int CNT_W = 4
);
   logic             start;
   logic             abort;
   logic             zflag;
   logic             ready;
   logic             busy;
   logic             done;
   logic             load;
   logic             psel;
   logic             reg_en;
   logic             shift_en;
   logic [CNT_W-1:0] iter;

   modport master (
      output start, abort, zflag,
      input  ready, busy, done,
      input  load, psel, reg_en, shift_en,
      input  iter
   );

   modport slave (
      input  start, abort, zflag,
      output ready, busy, done,
      output load, psel, reg_en, shift_en,
      output iter
   );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the shift-add signed multiplier datapath.
// All outputs are flops decoded from the next state, so no input reaches an output.
module mult_seq_ctrl #(
   parameter int N_BITS     = 8,
   parameter int CNT_W      = 4,
   parameter int EARLY_EXIT = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   mult_seq_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ADD,
      S_SHIFT,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BITS - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] iter_q, iter_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             load_q, load_d;
   logic             psel_q, psel_d;
   logic             reg_en_q, reg_en_d;
   logic             shift_en_q, shift_en_d;

   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = S_LOAD;
         end
         S_LOAD: begin
            iter_d  = '0;
            state_d = bus.abort ? S_IDLE : S_ADD;
         end
         S_ADD: begin
            if (bus.abort)
               state_d = S_IDLE;
            else if (EARLY_EXIT != 0 && bus.zflag)
               state_d = S_DONE;
            else
               state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else begin
               iter_d  = iter_q + CNT_W'(1);
               state_d = (iter_q == LAST) ? S_DONE : S_ADD;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Decode from the next state so the registered outputs line up with the state.
   always_comb begin
      ready_d    = (state_d == S_IDLE);
      busy_d     = (state_d == S_LOAD) || (state_d == S_ADD) ||
                   (state_d == S_SHIFT);
      done_d     = (state_d == S_DONE);
      load_d     = (state_d == S_LOAD);
      psel_d     = (state_d == S_ADD);
      reg_en_d   = (state_d == S_LOAD) || (state_d == S_ADD);
      shift_en_d = (state_d == S_SHIFT);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         iter_q     <= '0;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         load_q     <= 1'b0;
         psel_q     <= 1'b0;
         reg_en_q   <= 1'b0;
         shift_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         iter_q     <= iter_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         load_q     <= load_d;
         psel_q     <= psel_d;
         reg_en_q   <= reg_en_d;
         shift_en_q <= shift_en_d;
      end
   end

   assign bus.ready    = ready_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.load     = load_q;
   assign bus.psel     = psel_q;
   assign bus.reg_en   = reg_en_q;
   assign bus.shift_en = shift_en_q;
   assign bus.iter     = iter_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a behavioural sign-magnitude
// shift-add datapath closing the zflag loop.
module tb_mult_seq_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mult_seq_ctrl_if #(.CNT_W(4)) bus ();

   mult_seq_ctrl #(
      .N_BITS    (8),
      .CNT_W     (4),
      .EARLY_EXIT(1)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   logic [7:0]  mr_in = 8'h00;
   logic [7:0]  md_in = 8'h00;
   logic [7:0]  m_q   = 8'h00;
   logic [15:0] a_q   = 16'h0000;
   logic [15:0] p_q   = 16'h0000;
   logic        sgn_q = 1'b0;
   logic        zen   = 1'b0;

   function automatic logic [7:0] mag(input logic [7:0] v);
      return v[7] ? (~v + 8'd1) : v;
   endfunction

   always @(posedge clk) begin
      if (bus.load) begin
         m_q   <= mag(mr_in);
         a_q   <= {8'h00, mag(md_in)};
         sgn_q <= mr_in[7] ^ md_in[7];
      end else if (bus.shift_en) begin
         m_q <= m_q >> 1;
         a_q <= a_q << 1;
      end
      if (bus.reg_en)
         p_q <= bus.psel ? (m_q[0] ? p_q + a_q : p_q) : 16'h0000;
   end

   assign bus.zflag = zen & (m_q == 8'h00);

   int nload, load_at, load_at2, nshift;
   int ndone, done_at, done_at2;
   logic [3:0] iter_done;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in cycle T+1 (the LOAD cycle).
   task automatic start_op(input logic [7:0] mr, input logic [7:0] md);
      mr_in     = mr;
      md_in     = md;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic observe(input int ncyc);
      nload = 0; load_at = 0; load_at2 = 0; nshift = 0;
      ndone = 0; done_at = 0; done_at2 = 0; iter_done = '0;
      for (int c = 1; c <= ncyc; c++) begin
         if (c > 1) step();
         if (bus.load) begin
            nload++;
            if (nload == 1) load_at = c;
            else if (nload == 2) load_at2 = c;
         end
         if (bus.shift_en) nshift++;
         if (bus.done) begin
            ndone++;
            if (ndone == 1) begin
               done_at   = c;
               iter_done = bus.iter;
            end else if (ndone == 2) begin
               done_at2 = c;
            end
         end
      end
   endtask

   task automatic test_reset();
      logic [10:0] got;
      rst_n = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; zen = 1'b0;
      step(); step();
      got = {bus.ready, bus.busy, bus.done, bus.load, bus.psel,
             bus.reg_en, bus.shift_en, bus.iter};
      n_chk++;
      if (got !== {1'b1, 6'b0, 4'd0}) begin
         n_fail++;
         $display("FAIL reset_outputs got=%b exp=%b", got, {1'b1, 10'b0});
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_full_run();
      zen = 1'b0;
      start_op(8'hFD, 8'h05);
      observe(19);
      n_chk++;
      if (nload !== 1 || load_at !== 1) begin
         n_fail++;
         $display("FAIL full_load nload=%0d at=%0d exp 1 at 1", nload, load_at);
      end
      n_chk++;
      if (nshift !== 8) begin
         n_fail++;
         $display("FAIL full_shifts got=%0d exp=8", nshift);
      end
      n_chk++;
      if (ndone !== 1 || done_at !== 18) begin
         n_fail++;
         $display("FAIL full_done n=%0d at=%0d exp 1 at 18", ndone, done_at);
      end
      n_chk++;
      if (iter_done !== 4'd8) begin
         n_fail++;
         $display("FAIL full_iter got=%0d exp=8", iter_done);
      end
      n_chk++;
      if (p_q !== 16'd15 || sgn_q !== 1'b1) begin
         n_fail++;
         $display("FAIL full_product got=%0d/%b exp=15/1", p_q, sgn_q);
      end
      n_chk++;
      if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL full_idle ready=%b busy=%b exp 1/0", bus.ready, bus.busy);
      end
   endtask

   task automatic test_early_exit();
      zen = 1'b1;
      start_op(8'h00, 8'h7F);
      step();
      n_chk++;
      if (bus.psel !== 1'b1 || bus.reg_en !== 1'b1 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL early_add psel=%b reg_en=%b done=%b exp 1/1/0",
                  bus.psel, bus.reg_en, bus.done);
      end
      step();
      n_chk++;
      if (bus.done !== 1'b1 || bus.iter !== 4'd0) begin
         n_fail++;
         $display("FAIL early_done done=%b iter=%0d exp 1/0", bus.done, bus.iter);
      end
      n_chk++;
      if (p_q !== 16'd0) begin
         n_fail++;
         $display("FAIL early_product got=%0d exp=0", p_q);
      end
      step();
      n_chk++;
      if (bus.ready !== 1'b1 || bus.shift_en !== 1'b0) begin
         n_fail++;
         $display("FAIL early_idle ready=%b shift=%b exp 1/0", bus.ready, bus.shift_en);
      end
   endtask

   task automatic test_zflag_exit();
      zen = 1'b1;
      start_op(8'h02, 8'h03);
      observe(9);
      n_chk++;
      if (ndone !== 1 || done_at !== 7 || nshift !== 2) begin
         n_fail++;
         $display("FAIL zflag_done n=%0d at=%0d shifts=%0d exp 1/7/2",
                  ndone, done_at, nshift);
      end
      n_chk++;
      if (iter_done !== 4'd2) begin
         n_fail++;
         $display("FAIL zflag_iter got=%0d exp=2", iter_done);
      end
      n_chk++;
      if (p_q !== 16'd6 || sgn_q !== 1'b0) begin
         n_fail++;
         $display("FAIL zflag_product got=%0d/%b exp=6/0", p_q, sgn_q);
      end
   endtask

   task automatic test_abort();
      logic [6:0] got;
      int         nd_pre;
      zen = 1'b1;
      start_op(8'h7F, 8'h01);
      observe(6);
      nd_pre = ndone;
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      got = {bus.ready, bus.busy, bus.done, bus.load, bus.psel,
             bus.reg_en, bus.shift_en};
      n_chk++;
      if (got !== 7'b1000000 || nd_pre !== 0) begin
         n_fail++;
         $display("FAIL abort_idle got=%b ndone=%0d exp=1000000/0", got, nd_pre);
      end
      start_op(8'hFB, 8'hFB);
      observe(10);
      n_chk++;
      if (ndone !== 1 || done_at !== 9 || iter_done !== 4'd3) begin
         n_fail++;
         $display("FAIL abort_rerun n=%0d at=%0d iter=%0d exp 1/9/3",
                  ndone, done_at, iter_done);
      end
      n_chk++;
      if (p_q !== 16'd25 || sgn_q !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_product got=%0d/%b exp=25/0", p_q, sgn_q);
      end
   endtask

   task automatic test_back_to_back();
      int nl;
      zen       = 1'b0;
      mr_in     = 8'h03;
      md_in     = 8'h04;
      bus.start = 1'b1;
      step();
      observe(38);
      bus.start = 1'b0;
      n_chk++;
      if (nload !== 2 || load_at !== 1 || load_at2 !== 20) begin
         n_fail++;
         $display("FAIL b2b_loads n=%0d at=%0d,%0d exp 2 at 1,20",
                  nload, load_at, load_at2);
      end
      n_chk++;
      if (ndone !== 2 || done_at !== 18 || done_at2 !== 37) begin
         n_fail++;
         $display("FAIL b2b_done n=%0d at=%0d,%0d exp 2 at 18,37",
                  ndone, done_at, done_at2);
      end
      n_chk++;
      if (load_at2 - done_at !== 2) begin
         n_fail++;
         $display("FAIL b2b_gap got=%0d exp=2", load_at2 - done_at);
      end
      step(); step();
      start_op(8'h03, 8'h04);
      nl = 1;
      for (int c = 2; c <= 20; c++) begin
         bus.start = (c >= 3 && c <= 15 && (c % 3) == 0);
         step();
         if (bus.load) nl++;
      end
      bus.start = 1'b0;
      n_chk++;
      if (nl !== 1) begin
         n_fail++;
         $display("FAIL busy_start_ignored loads=%0d exp=1", nl);
      end
      n_chk++;
      if (p_q !== 16'd12) begin
         n_fail++;
         $display("FAIL b2b_product got=%0d exp=12", p_q);
      end
   endtask

   task automatic test_reset_mid();
      logic [10:0] got;
      zen = 1'b0;
      start_op(8'h7F, 8'h7F);
      step(); step(); step(); step();
      n_chk++;
      if (bus.shift_en !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_in_shift got=%b exp=1", bus.shift_en);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      got = {bus.ready, bus.busy, bus.done, bus.load, bus.psel,
             bus.reg_en, bus.shift_en, bus.iter};
      n_chk++;
      if (got !== {1'b1, 6'b0, 4'd0}) begin
         n_fail++;
         $display("FAIL rstmid_outputs got=%b exp=%b", got, {1'b1, 10'b0});
      end
      observe(20);
      n_chk++;
      if (ndone !== 0 || nload !== 0) begin
         n_fail++;
         $display("FAIL rstmid_quiet done=%0d load=%0d exp 0/0", ndone, nload);
      end
      zen = 1'b1;
      start_op(8'h02, 8'h03);
      observe(9);
      n_chk++;
      if (done_at !== 7 || p_q !== 16'd6) begin
         n_fail++;
         $display("FAIL rstmid_rerun at=%0d prod=%0d exp 7/6", done_at, p_q);
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      rst_n     = 1'b0;
      test_reset();
      test_full_run();
      test_early_exit();
      test_zflag_exit();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
